// File: rtl/deserializer_flex.sv
// deserializer_flex: multi-lane serial-to-parallel converter.
// Collects LANES bits per accepted beat into a DATA_BUS_WIDTH-bit word.
// The bit order is set by MSB_FIRST. data_last_i can close a partial word early,
// and deser_data_cnt_o reports how many bits of that word are valid.
// Both sides use ready/valid, and the output side has a single word register.
// Optional feature macro: DESER_FLEX_ERR_EN adds a sticky err_o flag. The flag
// records that a beat was offered while the converter was stalled.
module deserializer_flex #(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int LANES          = 1,
   parameter int MSB_FIRST      = 1,
   localparam int BEATS         = DATA_BUS_WIDTH / LANES,
   localparam int CNT_W         = $clog2(DATA_BUS_WIDTH + 1)
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic [LANES-1:0]          data_i,
   input  logic                      data_val_i,
   input  logic                      data_last_i,
   output logic                      data_ready_o,
   output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
   output logic [CNT_W-1:0]          deser_data_cnt_o,
   output logic                      deser_data_val_o,
   input  logic                      deser_data_ready_i
`ifdef DESER_FLEX_ERR_EN
   ,
   output logic                      err_o
`endif
);

   localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]  LANES_C   = CNT_W'(LANES);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

   logic [DATA_BUS_WIDTH-1:0] r_acc;
   logic [BCNT_W-1:0]         r_beat_cnt;
   logic [DATA_BUS_WIDTH-1:0] r_out_data;
   logic [CNT_W-1:0]          r_out_cnt;
   logic                      r_out_val;

   logic                      w_ready;
   logic                      w_accept;
   logic                      w_close;
   logic [DATA_BUS_WIDTH-1:0] w_merged;
   logic [CNT_W-1:0]          w_close_cnt;

   // A beat can enter whenever the output slot is empty or is being drained this cycle.
   assign w_ready  = !r_out_val || deser_data_ready_i;
   assign w_accept = data_val_i && w_ready;
   assign w_close  = w_accept && ((r_beat_cnt == LAST_BEAT) || data_last_i);

   // Place the current beat into its slot. Every other slot keeps its accumulator value.
   for (genvar g = 0; g < BEATS; g++) begin : g_slot
      localparam int POS = (MSB_FIRST != 0) ? (DATA_BUS_WIDTH - (g + 1) * LANES) : (g * LANES);
      assign w_merged[POS +: LANES] = (r_beat_cnt == BCNT_W'(g)) ? data_i : r_acc[POS +: LANES];
   end

   assign w_close_cnt = (CNT_W'(r_beat_cnt) + CNT_ONE) * LANES_C;

   // Accumulator and beat position. Both are cleared on close and frozen while stalled.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_acc      <= {DATA_BUS_WIDTH{1'b0}};
         r_beat_cnt <= {BCNT_W{1'b0}};
      end else if (w_close) begin
         r_acc      <= {DATA_BUS_WIDTH{1'b0}};
         r_beat_cnt <= {BCNT_W{1'b0}};
      end else if (w_accept) begin
         r_acc      <= w_merged;
         r_beat_cnt <= r_beat_cnt + BCNT_W'(1'b1);
      end else begin
         r_acc      <= r_acc;
         r_beat_cnt <= r_beat_cnt;
      end
   end

   // Output word register. A close in the same cycle as a drain takes priority.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_out_data <= {DATA_BUS_WIDTH{1'b0}};
         r_out_cnt  <= {CNT_W{1'b0}};
         r_out_val  <= 1'b0;
      end else if (w_close) begin
         r_out_data <= w_merged;
         r_out_cnt  <= w_close_cnt;
         r_out_val  <= 1'b1;
      end else if (r_out_val && deser_data_ready_i) begin
         r_out_data <= r_out_data;
         r_out_cnt  <= r_out_cnt;
         r_out_val  <= 1'b0;
      end else begin
         r_out_data <= r_out_data;
         r_out_cnt  <= r_out_cnt;
         r_out_val  <= r_out_val;
      end
   end

   assign data_ready_o     = w_ready;
   assign deser_data_o     = r_out_data;
   assign deser_data_cnt_o = r_out_cnt;
   assign deser_data_val_o = r_out_val;

`ifdef DESER_FLEX_ERR_EN
   logic r_err;

   // Sticky flag: a beat was offered while the output slot was blocked.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err || (data_val_i && !w_ready);
      end
   end

   assign err_o = r_err;
`endif

endmodule

// File: tb/tb_deserializer_flex.sv
// Directed testbench for deserializer_flex. It uses four instances:
//   a: W=16 L=1 MSB first
//   b: W=16 L=4 LSB first
//   c: W=16 L=4 MSB first
//   d: W=8  L=2 MSB first
// The inputs change and the outputs are sampled on the falling clock edge.
module tb_deserializer_flex;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic        a_d, a_v, a_l, a_r, a_ro, a_qv;
   logic [15:0] a_q;
   logic [4:0]  a_c;
   logic [3:0]  b_d;
   logic        b_v, b_l, b_r, b_ro, b_qv;
   logic [15:0] b_q;
   logic [4:0]  b_c;
   logic [3:0]  c_d;
   logic        c_v, c_l, c_r, c_ro, c_qv;
   logic [15:0] c_q;
   logic [4:0]  c_c;
   logic [1:0]  d_d;
   logic        d_v, d_l, d_r, d_ro, d_qv;
   logic [7:0]  d_q;
   logic [3:0]  d_c;
`ifdef DESER_FLEX_ERR_EN
   logic a_err, b_err, c_err, d_err;
`endif

   deserializer_flex #(.DATA_BUS_WIDTH(16), .LANES(1), .MSB_FIRST(1)) u_a (
      .clk_i(clk), .arst_n_i(rst_n), .data_i(a_d), .data_val_i(a_v), .data_last_i(a_l),
      .data_ready_o(a_ro), .deser_data_o(a_q), .deser_data_cnt_o(a_c),
      .deser_data_val_o(a_qv), .deser_data_ready_i(a_r)
`ifdef DESER_FLEX_ERR_EN
      , .err_o(a_err)
`endif
   );

   deserializer_flex #(.DATA_BUS_WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_b (
      .clk_i(clk), .arst_n_i(rst_n), .data_i(b_d), .data_val_i(b_v), .data_last_i(b_l),
      .data_ready_o(b_ro), .deser_data_o(b_q), .deser_data_cnt_o(b_c),
      .deser_data_val_o(b_qv), .deser_data_ready_i(b_r)
`ifdef DESER_FLEX_ERR_EN
      , .err_o(b_err)
`endif
   );

   deserializer_flex #(.DATA_BUS_WIDTH(16), .LANES(4), .MSB_FIRST(1)) u_c (
      .clk_i(clk), .arst_n_i(rst_n), .data_i(c_d), .data_val_i(c_v), .data_last_i(c_l),
      .data_ready_o(c_ro), .deser_data_o(c_q), .deser_data_cnt_o(c_c),
      .deser_data_val_o(c_qv), .deser_data_ready_i(c_r)
`ifdef DESER_FLEX_ERR_EN
      , .err_o(c_err)
`endif
   );

   deserializer_flex #(.DATA_BUS_WIDTH(8), .LANES(2), .MSB_FIRST(1)) u_d (
      .clk_i(clk), .arst_n_i(rst_n), .data_i(d_d), .data_val_i(d_v), .data_last_i(d_l),
      .data_ready_o(d_ro), .deser_data_o(d_q), .deser_data_cnt_o(d_c),
      .deser_data_val_o(d_qv), .deser_data_ready_i(d_r)
`ifdef DESER_FLEX_ERR_EN
      , .err_o(d_err)
`endif
   );

   // Counts one comparison and reports it when the observed value differs from the expected one.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Continuous-stream table for instance d: beat, last flag, and the expected outputs after the beat.
   logic [1:0] t5_d  [10] = '{2'h1, 2'h2, 2'h3, 2'h0, 2'h3, 2'h3, 2'h0, 2'h1, 2'h2, 2'h1};
   logic       t5_l  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic       t5_v  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [7:0] t5_q  [10] = '{8'h00, 8'h00, 8'h00, 8'h6C, 8'h6C, 8'h6C, 8'h6C, 8'hF1, 8'h80, 8'h40};
   logic [3:0] t5_c  [10] = '{4'd0, 4'd0, 4'd0, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd2, 4'd2};
   logic [3:0] t2_d  [4]  = '{4'h1, 4'h2, 4'h3, 4'h4};
   logic [3:0] t3_d  [4]  = '{4'hC, 4'hD, 4'hE, 4'hF};
   logic [3:0] t4_d  [4]  = '{4'h5, 4'h6, 4'h7, 4'h8};
   logic [1:0] t6_d  [4]  = '{2'h3, 2'h0, 2'h3, 2'h0};

   // Watchdog: the run must always end on its own.
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Main directed sequence.
   initial begin
      a_d = 1'b0; a_v = 1'b0; a_l = 1'b0; a_r = 1'b1;
      b_d = 4'h0; b_v = 1'b0; b_l = 1'b0; b_r = 1'b1;
      c_d = 4'h0; c_v = 1'b0; c_l = 1'b0; c_r = 1'b1;
      d_d = 2'h0; d_v = 1'b0; d_l = 1'b0; d_r = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_a_val", a_qv, 0);
      chk("rst_a_data", a_q, 0);
      chk("rst_a_cnt", a_c, 0);
      chk("rst_a_ready", a_ro, 1);
      chk("rst_d_val", d_qv, 0);
`ifdef DESER_FLEX_ERR_EN
      chk("rst_c_err", c_err, 0);
`endif
      rst_n = 1'b1;

      // 16 single-bit beats 1,0,1,0,... MSB first give 0xAAAA.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 15) chk("t1_not_early", a_qv, 0);
         a_d = ((i % 2) == 0) ? 1'b1 : 1'b0;
         a_v = 1'b1;
      end
      @(negedge clk);
      a_v = 1'b0;
      chk("t1_val", a_qv, 1);
      chk("t1_data", a_q, 16'hAAAA);
      chk("t1_cnt", a_c, 16);
      @(negedge clk);
      chk("t1_drained", a_qv, 0);
      chk("t1_hold", a_q, 16'hAAAA);

      // Four-lane beats 1,2,3,4 in both bit orders.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_d = t2_d[i]; c_d = t2_d[i];
         b_v = 1'b1;    c_v = 1'b1;
      end
      @(negedge clk);
      b_v = 1'b0; c_v = 1'b0;
      chk("t2_lsb_val", b_qv, 1);
      chk("t2_lsb_data", b_q, 16'h4321);
      chk("t2_lsb_cnt", b_c, 16);
      chk("t2_msb_data", c_q, 16'h1234);
      chk("t2_msb_cnt", c_c, 16);

      // Early flush after two beats, then a full word must start again from beat 0.
      @(negedge clk);
      c_d = 4'hA; c_v = 1'b1; c_l = 1'b0;
      @(negedge clk);
      c_d = 4'hB; c_l = 1'b1;
      @(negedge clk);
      c_v = 1'b0; c_l = 1'b0;
      chk("t3_flush_val", c_qv, 1);
      chk("t3_flush_data", c_q, 16'hAB00);
      chk("t3_flush_cnt", c_c, 8);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         c_d = t3_d[i]; c_v = 1'b1;
      end
      @(negedge clk);
      c_v = 1'b0;
      chk("t3_next_data", c_q, 16'hCDEF);
      chk("t3_next_cnt", c_c, 16);

      // Stall: downstream holds ready low while the upstream keeps offering beats.
      @(negedge clk);
      c_r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         c_d = t2_d[i]; c_v = 1'b1;
      end
      @(negedge clk);
      chk("t4_word_val", c_qv, 1);
      chk("t4_word_data", c_q, 16'h1234);
`ifdef DESER_FLEX_ERR_EN
      chk("t4_err_clear", c_err, 0);
`endif
      c_d = 4'h9; c_v = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_ready_low", c_ro, 0);
         chk("t4_hold_val", c_qv, 1);
         chk("t4_hold_data", c_q, 16'h1234);
`ifdef DESER_FLEX_ERR_EN
         chk("t4_err_set", c_err, 1);
`endif
      end
      c_r = 1'b1; c_v = 1'b0;
      @(negedge clk);
      chk("t4_release", c_qv, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         c_d = t4_d[i]; c_v = 1'b1;
      end
      @(negedge clk);
      c_v = 1'b0;
      chk("t4_after_data", c_q, 16'h5678);
      chk("t4_after_cnt", c_c, 16);
`ifdef DESER_FLEX_ERR_EN
      chk("t4_err_sticky", c_err, 1);
`endif

      // Continuous stream with no gaps. The two flushed words arrive back to back.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("t5_val", d_qv, t5_v[i-1]);
            chk("t5_data", d_q, t5_q[i-1]);
            chk("t5_cnt", d_c, t5_c[i-1]);
            chk("t5_ready", d_ro, 1);
         end
         d_d = t5_d[i]; d_l = t5_l[i]; d_v = 1'b1;
      end
      @(negedge clk);
      d_v = 1'b0; d_l = 1'b0;
      chk("t5_last_val", d_qv, 1);
      chk("t5_last_data", d_q, 8'h40);
      @(negedge clk);
      chk("t5_idle_val", d_qv, 0);
      chk("t5_idle_hold", d_q, 8'h40);
      chk("t5_idle_cnt", d_c, 2);

      // Reset in the middle of a word, then a fresh word.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         d_d = 2'h3; d_v = 1'b1;
      end
      @(negedge clk);
      d_v = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_data", d_q, 0);
      chk("t6_rst_cnt", d_c, 0);
      chk("t6_rst_val", d_qv, 0);
      chk("t6_rst_ready", d_ro, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 3) chk("t6_no_emit", d_qv, 0);
         d_d = t6_d[i]; d_v = 1'b1;
      end
      @(negedge clk);
      d_v = 1'b0;
      chk("t6_val", d_qv, 1);
      chk("t6_data", d_q, 8'hCC);
      chk("t6_cnt", d_c, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/deserializer_flex.md
# deserializer_flex

Parametrised multi-lane serial-to-parallel converter, successor to the single-bit deserializer. Collects `LANES` bits per accepted beat into a `DATA_BUS_WIDTH`-bit word, in configurable bit order. Supports early flush of a partial word with a valid-bit count. Uses a ready/valid handshake on both sides with a one-word output register. Sits between serial line receivers and word-oriented datapath logic that may apply backpressure.

## Interface
- `DATA_BUS_WIDTH`, 16: output word width. Must be a multiple of `LANES` and ≥ `LANES`.
- `LANES`, 1: bits accepted per beat (1, 2, 4, 8, …).
- `MSB_FIRST`, 1: 1 = first beat lands in the top bits; 0 = first beat lands in the bottom bits.
- Derived: `BEATS = DATA_BUS_WIDTH/LANES`; `CNT_W = $clog2(DATA_BUS_WIDTH+1)`.

Ports:
- `clk_i` in 1: single clock.
- `arst_n_i` in 1: reset, asynchronous and active-low.
- `data_i` in `LANES`: serial beat; bit `LANES-1` is the earliest in time when `MSB_FIRST`=1.
- `data_val_i` in 1: beat valid.
- `data_last_i` in 1: with an accepted beat, closes the word after this beat (flush).
- `data_ready_o` out 1: beat accepted when `data_val_i && data_ready_o`.
- `deser_data_o` out `DATA_BUS_WIDTH`: assembled word.
- `deser_data_cnt_o` out `CNT_W`: number of valid bits in `deser_data_o`.
- `deser_data_val_o` out 1: output word valid.
- `deser_data_ready_i` in 1: downstream accepts the word.
- `err_o` out 1: present only with `DESER_FLEX_ERR_EN`.

## Operation
- Accumulator `acc` (`DATA_BUS_WIDTH`) and beat counter `beat_cnt` (0..`BEATS-1`). On accept, beat k is written:
  - `MSB_FIRST`=1: to bits `[DATA_BUS_WIDTH-1-k*LANES -: LANES]`.
  - `MSB_FIRST`=0: to bits `[k*LANES +: LANES]`.
- Word closes on an accepted beat when `beat_cnt == BEATS-1` or `data_last_i`=1. On close:
  - output register ← `acc` merged with the current beat; unfilled positions are 0;
  - `deser_data_cnt_o` ← `(beat_cnt+1)*LANES`;
  - `deser_data_val_o` ← 1;
  - `acc` ← 0, `beat_cnt` ← 0.
- Non-closing accept: write the beat into `acc`, `beat_cnt` +1.
- Output register holds its value until `deser_data_val_o && deser_data_ready_i`. Then `deser_data_val_o` ← 0, unless a new close occurs in the same cycle, which reloads the register and keeps valid high.
- `data_ready_o = !deser_data_val_o || deser_data_ready_i`. This is combinational from `deser_data_ready_i` and applies to every beat, not only closing beats.
- `data_last_i` is ignored when the beat is not accepted.
- `data_last_i` on the first beat produces a word with `cnt = LANES`.

## Timing
- Reset (async assert, sync-released by the integrator):
  - `acc` = 0, `beat_cnt` = 0;
  - `deser_data_o` = 0, `deser_data_cnt_o` = 0, `deser_data_val_o` = 0;
  - `err_o` = 0;
  - `data_ready_o` = 1.
- Latency: the closing beat accepted at edge N gives `deser_data_val_o`=1 after edge N.
- Throughput: one beat per cycle while the downstream keeps `deser_data_ready_i`=1. Back-to-back words with no bubble.
- Stall: while the output is valid and not taken, no beats are accepted. `acc` and `beat_cnt` are frozen.
- Reset mid-word: the partial word is discarded, nothing is emitted, and the next accepted beat is beat 0.
- `deser_data_o` and `deser_data_cnt_o` change only on close; they keep their last values when valid is low.

## Configuration
- `DESER_FLEX_ERR_EN` defined:
  - output `err_o` exists;
  - it is a sticky flag, set the cycle after `data_val_i && !data_ready_o` (beat offered while stalled);
  - cleared only by reset.
- Not defined: port `err_o` is absent, no flag logic is built, and offered-while-stalled beats are simply not accepted.

## Test plan
- W=16, L=1, MSB_FIRST=1, ready=1: beats 1,0,1,0,… (16 beats) → one word 0xAAAA, cnt=16, valid exactly 1 cycle after beat 16.
- W=16, L=4, MSB_FIRST=0: beats 0x1,0x2,0x3,0x4 → 0x4321, cnt=16. Repeat with MSB_FIRST=1 → 0x1234.
- W=16, L=4, MSB_FIRST=1: beats 0xA,0xB with `data_last_i` on the 2nd → 0xAB00, cnt=8. The next word starts at beat 0.
- Downstream ready held 0 for 5 cycles after a word: `data_ready_o`=0 during the hold, the word is stable, following beats are not accepted, and with ERR_EN `err_o` rises after the first offered beat and stays high.
- Continuous beats with ready=1, W=8, L=2: words every 4 cycles with no gaps, and simultaneous drain + close keeps valid high.
- `arst_n_i` pulsed low after 3 of 4 beats (W=8, L=2): all outputs are 0 immediately, then 4 fresh beats 0x3,0x0,0x3,0x0 → 0xCC.
